// File: rtl/if_id_queue.sv
// Fetch-to-decode FWFT instruction queue: one-cycle push-to-head latency, NOP bubble when empty.
// Backpressure: in_ready drops only when full (independent of out_ready); flush empties it in one edge.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_instr,
  output logic                         out_illegal,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic [DEPTH-1:0][XLEN-1:0] pc_mem;
  logic [DEPTH-1:0][XLEN-1:0] instr_mem;
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              wr_ptr;
  logic [CW-1:0]              occ;
  logic                       push;
  logic                       pop;

  assign in_ready  = (occ < CW'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = occ;

  // Head is read straight from storage; an empty queue shows a canonical bubble.
  assign out_pc      = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr   = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign out_illegal = out_valid && (out_instr[1:0] != 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_mem    <= '0;
      instr_mem <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      occ    <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= in_pc;
        instr_mem[wr_ptr] <= in_instr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int checks;
  int passes;

  entry_t mq[$];

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_illegal(out_illegal), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1);
  end

  // Reference: plain FIFO of entries, decisions made from the queue length.
  function automatic logic        m_valid();  return mq.size() != 0; endfunction
  function automatic logic        m_ready();  return mq.size() < DEPTH; endfunction
  function automatic logic [2:0]  m_count();  return 3'(mq.size()); endfunction
  function automatic logic [31:0] m_pc();     return (mq.size() != 0) ? mq[0].pc : 32'h0; endfunction
  function automatic logic [31:0] m_instr();  return (mq.size() != 0) ? mq[0].instr : 32'h13; endfunction
  function automatic logic        m_illegal();
    return (mq.size() != 0) && (mq[0].instr[1:0] != 2'b11);
  endfunction

  // Advance one clock edge and apply the same transaction to the model.
  task automatic step();
    bit     do_push, do_pop, do_flush;
    entry_t e;
    do_flush = flush;
    do_push  = in_valid && (mq.size() < DEPTH);
    do_pop   = out_ready && (mq.size() != 0);
    e.pc     = in_pc;
    e.instr  = in_instr;
    @(posedge clk);
    #1;
    if (do_flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else passes++;
    checks++; if (out_instr !== 32'h13) $display("FAIL reset_out_instr got=%h exp=00000013", out_instr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got=%h exp=0", out_pc); else passes++;
    checks++; if (out_illegal !== 1'b0) $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_stall();
    logic [31:0] ins [4];
    ins[0] = 32'h00500093; ins[1] = 32'h00100113; ins[2] = 32'h002081B3; ins[3] = 32'h00000013;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = ins[i];
      step();
      checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); else passes++;
    end
    checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", in_ready); else passes++;
    in_pc = 32'h10; in_instr = 32'h0000_0093;
    step();
    checks++; if (count !== 3'd4) $display("FAIL fill_5th_count got=%0d exp=4", count); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL fill_head_pc got=%h exp=0", out_pc); else passes++;
    checks++; if (out_instr !== 32'h00500093) $display("FAIL fill_head_instr got=%h exp=00500093", out_instr); else passes++;
    in_valid = 1'b0;
  endtask

  task automatic test_full_pop();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h99; in_instr = 32'h0000_0033;
    checks++; if (in_ready !== 1'b0) $display("FAIL fullpop_in_ready_before got=%b exp=0", in_ready); else passes++;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) $display("FAIL fullpop_count got=%0d exp=3", count); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL fullpop_in_ready_after got=%b exp=1", in_ready); else passes++;
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_pc !== 32'(i * 4)) $display("FAIL fullpop_drain_pc[%0d] got=%h exp=%h", i, out_pc, i * 4); else passes++;
      step();
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = 32'h0000_0013 | 32'(i << 7);
      if (i > 0) begin
        checks++; if (out_pc !== 32'((i - 1) * 4)) $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, (i - 1) * 4); else passes++;
      end
      step();
      checks++; if (count !== 3'd1) $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); else passes++;
    end
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h24) $display("FAIL stream_last_pc got=%h exp=24", out_pc); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL stream_drained got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h30 + 32'(i * 4); in_instr = 32'h0000_0013;
      step();
    end
    checks++; if (count !== 3'd3) $display("FAIL flush_pre_count got=%0d exp=3", count); else passes++;
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_during got=%b exp=1", in_ready); else passes++;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", count); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else passes++;
    in_valid = 1'b1; in_pc = 32'h80; in_instr = 32'h0000_0013;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h80) $display("FAIL flush_resume_pc got=%h exp=80", out_pc); else passes++;
    checks++; if (count !== 3'd1) $display("FAIL flush_resume_count got=%0d exp=1", count); else passes++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0000_0001;
    step();
    in_pc = 32'h104; in_instr = 32'h0000_0013;
    checks++; if (out_illegal !== 1'b1) $display("FAIL illegal_set got=%b exp=1", out_illegal); else passes++;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_illegal !== 1'b0) $display("FAIL illegal_legal_head got=%b exp=0", out_illegal); else passes++;
    checks++; if (out_pc !== 32'h104) $display("FAIL illegal_second_pc got=%h exp=104", out_pc); else passes++;
    step();
    out_ready = 1'b0;
    checks++; if (out_illegal !== 1'b0) $display("FAIL illegal_empty got=%b exp=0", out_illegal); else passes++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(i * 4); in_instr = 32'h0000_0013;
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) $display("FAIL areset_pre_count got=%0d exp=3", count); else passes++;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    checks++; if (count !== 3'd0) $display("FAIL areset_count got=%0d exp=0", count); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid got=%b exp=0", out_valid); else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL areset_no_delivery got=%b exp=0", out_valid); else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      checks++; if (out_valid !== m_valid()) $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", c, out_valid, m_valid()); else passes++;
      checks++; if (in_ready !== m_ready()) $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, in_ready, m_ready()); else passes++;
      checks++; if (count !== m_count()) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, count, m_count()); else passes++;
      checks++; if (out_pc !== m_pc()) $display("FAIL rnd_out_pc[%0d] got=%h exp=%h", c, out_pc, m_pc()); else passes++;
      checks++; if (out_instr !== m_instr()) $display("FAIL rnd_out_instr[%0d] got=%h exp=%h", c, out_instr, m_instr()); else passes++;
      checks++; if (out_illegal !== m_illegal()) $display("FAIL rnd_out_illegal[%0d] got=%b exp=%b", c, out_illegal, m_illegal()); else passes++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_fill_stall();
    test_full_pop();
    test_streaming();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (`if_stage`) and the decode stage. Each cycle fetch offers a (PC, instruction) pair, and decode consumes pairs in order. A valid/ready handshake on both sides lets decode stall without losing fetched words. A synchronous flush discards everything in flight after a taken branch or jump. While empty, the queue presents a canonical NOP bubble to decode.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.
- `XLEN`, default 32: width of the PC and instruction fields.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: fetch presents a valid pair.
- `in_pc`, in, XLEN: PC of the fetched instruction.
- `in_instr`, in, XLEN: fetched instruction word.
- `in_ready`, out, 1: queue can accept a pair this cycle.
- `out_valid`, out, 1: head entry is valid.
- `out_pc`, out, XLEN: PC of the head entry.
- `out_instr`, out, XLEN: instruction of the head entry.
- `out_illegal`, out, 1: head instruction has `instr[1:0] != 2'b11` (not a 32-bit encoding).
- `out_ready`, in, 1: decode consumes the head entry this cycle.
- `flush`, in, 1: discard all entries (synchronous).
- `count`, out, $clog2(DEPTH+1): current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {pc, instr}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count < DEPTH)`. It does not depend on `out_ready`: when full, a same-cycle pop does not enable a push.
- `out_valid = (count != 0)`. First-word-fall-through: the head entry is visible combinationally from the registered storage.
- Empty-queue outputs:
  - `out_pc = 0`
  - `out_instr = 32'h00000013` (NOP)
  - `out_illegal = 0`
- There is no bypass from input to output. A push into an empty queue becomes visible on the next cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- `count` next-state update:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- Flush has highest priority:
  - On a rising edge with `flush = 1`, count → 0 and read pointer := write pointer.
  - A same-cycle push is dropped and a same-cycle pop is ignored.
  - `in_ready` is not gated by `flush`.
- `out_illegal = out_valid && (out_instr[1:0] != 2'b11)`.

## Timing
- Reset (asynchronous assert, synchronous deassert externally):
  - count = 0, both pointers = 0, all storage entries = 0.
  - `out_valid = 0`, `in_ready = 1`, `out_pc = 0`, `out_instr = 32'h00000013`, `out_illegal = 0`.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Entries are never delivered after reset.
- Latency: a pair pushed at edge N appears at the output during cycle N+1 (one cycle, minimum).
- Throughput: one push and one pop per cycle in steady state when not full.
- When full: `in_ready = 0` until a pop completes. It rises the cycle after the pop edge.
- After a flush edge: `out_valid = 0` and `in_ready = 1` in the following cycle. Accepted pairs resume on the next edge.
- All outputs except the combinational head read are registered-state derived. There are no combinational paths from `in_*` to `out_*`.

## Test plan
- Reset: assert `reset` for 2 cycles → `out_valid = 0`, `in_ready = 1`, `count = 0`, `out_instr = 0x00000013`, `out_pc = 0`. Assert `reset` asynchronously between edges while count = 3 → count = 0 immediately.
- Fill/stall: hold `out_ready = 0` and push PC 0x00, 0x04, 0x08, 0x0C with instr 0x00500093, 0x00100113, 0x002081B3, 0x00000013:
  - After 4 pushes: `in_ready = 0`, `count = 4`.
  - A 5th `in_valid` is not accepted.
  - Head shows PC 0x00, instr 0x00500093.
- Streaming: `in_valid = out_ready = 1` for 10 cycles with PCs 0x00..0x24:
  - `count` stays at 1 after the first cycle.
  - Output PCs appear in order with 1-cycle lag and no gaps or duplicates.
  - Pointers wrap past DEPTH-1 with no corruption.
- Full with simultaneous pop: count = 4, `out_ready = 1`, `in_valid = 1` → pop only, count = 3, the new pair is not stored. On the next cycle `in_ready = 1`.
- Flush: count = 3, assert `flush` with `in_valid = 1` (PC 0x40) and `out_ready = 1`:
  - Next cycle: count = 0, `out_valid = 0`, PC 0x40 is not present.
  - A subsequent push of PC 0x80 appears as the head one cycle later.
- Illegal flag: push instr 0x00000001 → `out_illegal = 1` while it is the head. Push 0x00000013 → `out_illegal = 0`. When the queue is empty → `out_illegal = 0`.
